// File: rtl/ironhorse_audio_pkg.sv
// Shared types, limits and the saturation helper for the Iron Horse audio output path.
// Optional DC blocker in this path is enabled with IRONHORSE_AUDIO_DCBLOCK_EN.
package ironhorse_audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Clamp a wider signed value into the 16-bit sample range; callers sign-extend to 32 bits first.
  function automatic sample_t sat16(input logic signed [31:0] v);
    sample_t r;
    if (v > 32'sd32767) begin
      r = SAMPLE_MAX;
    end else if (v < -32'sd32768) begin
      r = SAMPLE_MIN;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ironhorse_audio_dcblk.sv
// First-order DC blocker, stepped once per decimated sample.
// Only instantiated when IRONHORSE_AUDIO_DCBLOCK_EN is defined.
// y holds the stored (saturated) filter output, which is also the feedback term.
module ironhorse_audio_dcblk
  import ironhorse_audio_pkg::*;
#(
  parameter int DCB_K = 10
) (
  input  logic    clk_49m,
  input  logic    reset,
  input  logic    stb_in,
  input  sample_t x,
  output logic    stb_out,
  output sample_t y
);

  sample_t            x_prev;
  logic signed [19:0] y_next;

  // Filter equation evaluated at 20 bits so the difference terms cannot wrap before saturation.
  always_comb begin
    y_next = 20'(x) - 20'(x_prev) + 20'(y) - (20'(y) >>> DCB_K);
  end

  // Filter state advances only on an incoming sample; the strobe is delayed to match.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      x_prev  <= '0;
      y       <= '0;
      stb_out <= 1'b0;
    end else begin
      stb_out <= stb_in;
      if (stb_in) begin
        x_prev <= x;
        y      <= sat16(32'(y_next));
      end
    end
  end

endmodule

// File: rtl/ironhorse_audio_out.sv
// Iron Horse final audio stage: boxcar decimation of the mixed sound to 48kHz,
// 0..3-bit power-of-two gain with saturation, mute, and a one-clock sample strobe.
// Defining IRONHORSE_AUDIO_DCBLOCK_EN inserts a DC blocker before the gain stage,
// adding one clock of latency.
module ironhorse_audio_out
  import ironhorse_audio_pkg::*;
#(
  parameter int DIV      = 1024,
  parameter int LOG2_DIV = 10,
  parameter int DCB_K    = 10
) (
  input  logic               clk_49m,
  input  logic               reset,
  input  logic signed [15:0] in_sample,
  input  logic [1:0]         gain,
  input  logic               mute,
  output logic signed [15:0] out_sample,
  output logic               out_stb
);

  localparam int ACC_W = LOG2_DIV + 16;

  // Catch inconsistent decimation or filter parameters at elaboration.
  if (DIV != (1 << LOG2_DIV) || LOG2_DIV < 1 || LOG2_DIV > 12) begin : g_bad_div
    $error("ironhorse_audio_out: DIV must equal 2**LOG2_DIV within 2..4096");
  end
  if (DCB_K < 1 || DCB_K > 15) begin : g_bad_dcb
    $error("ironhorse_audio_out: DCB_K out of range");
  end

  logic [LOG2_DIV-1:0]     cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    win_end;
  sample_t                 avg_r;
  logic                    avg_stb;
  sample_t                 gain_in;
  logic                    gain_stb;
  logic signed [18:0]      shifted;

  // Running sum including the sample presented this clock, so the window-end edge
  // folds the last sample into the average without dropping it.
  always_comb begin
    win_end = (cnt == LOG2_DIV'(DIV - 1));
    acc_sum = acc + ACC_W'(in_sample);
  end

  // Accumulate every clock; at window end publish the floored mean and restart the window.
  // Taking the top 16 bits of the sum is the arithmetic shift right by LOG2_DIV.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= '0;
      avg_r   <= '0;
      avg_stb <= 1'b0;
    end else begin
      avg_stb <= win_end;
      if (win_end) begin
        cnt   <= '0;
        acc   <= '0;
        avg_r <= acc_sum[ACC_W-1:LOG2_DIV];
      end else begin
        cnt <= cnt + LOG2_DIV'(1);
        acc <= acc_sum;
      end
    end
  end

`ifdef IRONHORSE_AUDIO_DCBLOCK_EN
  ironhorse_audio_dcblk #(
    .DCB_K (DCB_K)
  ) u_dcblk (
    .clk_49m (clk_49m),
    .reset   (reset),
    .stb_in  (avg_stb),
    .x       (avg_r),
    .stb_out (gain_stb),
    .y       (gain_in)
  );
`else
  assign gain_stb = avg_stb;
  assign gain_in  = avg_r;
`endif

  // Gain applied at 19 bits so a 3-bit shift of any sample is exact before clamping.
  always_comb begin
    shifted = 19'(gain_in) <<< gain;
  end

  // Output register: updates only on the strobe and holds in between; gain and mute
  // are looked at only on that edge.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      out_sample <= '0;
      out_stb    <= 1'b0;
    end else begin
      out_stb <= gain_stb;
      if (gain_stb) begin
        out_sample <= mute ? '0 : sat16(32'(shifted));
      end
    end
  end

endmodule

// File: tb/tb_ironhorse_audio_out.sv
// Testbench for ironhorse_audio_out; follows IRONHORSE_AUDIO_DCBLOCK_EN for latency and filtering.
module tb_ironhorse_audio_out;
  import ironhorse_audio_pkg::*;

  localparam int DIV      = 1024;
  localparam int LOG2_DIV = 10;
  localparam int DCB_K    = 10;
`ifdef IRONHORSE_AUDIO_DCBLOCK_EN
  localparam int STB_IDX = 2;
  localparam bit DCB_ON  = 1'b1;
`else
  localparam int STB_IDX = 1;
  localparam bit DCB_ON  = 1'b0;
`endif

  logic               clk_49m = 1'b0;
  logic               reset;
  logic signed [15:0] in_sample;
  logic [1:0]         gain;
  logic               mute;
  logic signed [15:0] out_sample;
  logic               out_stb;

  int    tests = 0;
  int    fails = 0;
  int    have_pend = 0;
  int    pend_avg = 0;
  int    pend_gain = 0;
  int    pend_mute = 0;
  string pend_tag = "none";
  int    dc_x = 0;
  int    dc_y = 0;

  always #5 clk_49m = ~clk_49m;

  ironhorse_audio_out #(
    .DIV      (DIV),
    .LOG2_DIV (LOG2_DIV),
    .DCB_K    (DCB_K)
  ) dut (
    .clk_49m    (clk_49m),
    .reset      (reset),
    .in_sample  (in_sample),
    .gain       (gain),
    .mute       (mute),
    .out_sample (out_sample),
    .out_stb    (out_stb)
  );

  // Mathematical floor of n/d for positive d.
  function automatic int floor_div(input longint n, input longint d);
    if (n >= 0) return int'(n / d);
    return int'(-((-n + d - 1) / d));
  endfunction

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Output value for a decimated (optionally filtered) sample under the given gain and mute.
  function automatic int apply_out(input int v, input int g, input int m);
    if (m != 0) return 0;
    return clamp16(longint'(v) * longint'(1 << g));
  endfunction

  // Reference DC blocker: one step per produced sample.
  task automatic dc_step(input int avg, output int y);
    longint t;
    t = longint'(avg) - dc_x + dc_y - floor_div(dc_y, 64'(1) << DCB_K);
    dc_x = avg;
    dc_y = clamp16(t);
    y = dc_y;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gen(input int mode, input int i, input int c);
    case (mode)
      0: return c;
      1: return ((i % 2) == 0) ? c : -c;
      2: return int'($urandom_range(65535)) - 32768;
      default: return int'($urandom_range(200)) - 100;
    endcase
  endfunction

  // Drive n samples (one per clock). While doing so, check the strobe of the previous
  // full window; a full window becomes the next pending result with gain g / mute m.
  task automatic run_window(input int mode, input int c, input int n, input int g, input int m,
                            input string tag);
    longint sum;
    int v, y, nstb, exp_v;
    sum = 0;
    nstb = 0;
    exp_v = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_49m);
      if (out_stb === 1'b1) nstb++;
      if (i == 0) begin
        if (have_pend != 0) begin
          if (DCB_ON) dc_step(pend_avg, y);
          else y = pend_avg;
          exp_v = apply_out(y, pend_gain, pend_mute);
        end
        gain = 2'(pend_gain);
        mute = pend_mute[0];
      end
      if (have_pend != 0 && i == STB_IDX) begin
        check({pend_tag, "_stb"}, 32'(out_stb), 1);
        check({pend_tag, "_val"}, 32'(out_sample), exp_v);
      end
      if (have_pend != 0 && i == STB_IDX + 5) begin
        check({pend_tag, "_hold"}, 32'(out_sample), exp_v);
      end
      if (i == DIV / 2) begin
        gain = 2'($urandom_range(3));
        mute = 1'($urandom_range(1));
      end
      v = gen(mode, i, c);
      in_sample = 16'(v);
      sum += v;
    end
    check({tag, "_stbcount"}, nstb, (have_pend != 0) ? 1 : 0);
    if (n == DIV) begin
      pend_avg  = floor_div(sum, DIV);
      pend_gain = g;
      pend_mute = m;
      pend_tag  = tag;
      have_pend = 1;
    end else begin
      have_pend = 0;
    end
  endtask

  // Release reset just after a rising edge so the next edge is edge 1 of a fresh window.
  task automatic release_reset();
    @(posedge clk_49m);
    #2 reset = 1'b1;
    have_pend = 0;
    dc_x = 0;
    dc_y = 0;
  endtask

  initial begin
    reset = 1'b1;
    in_sample = '0;
    gain = '0;
    mute = 1'b0;
    #1 reset = 1'b0;
    #20;
    check("reset_out", 32'(out_sample), 0);
    check("reset_stb", 32'(out_stb), 0);
    release_reset();

    run_window(0, 1000, DIV, 0, 0, "c1000_a");
    run_window(0, 1000, DIV, 0, 0, "c1000_b");
    run_window(0, 1000, DIV, 0, 0, "c1000_c");
    run_window(0, 20000, DIV, 2, 0, "satpos");
    run_window(0, -20000, DIV, 2, 0, "satneg");
    run_window(0, -3, DIV, 3, 0, "neg3_g3");
    run_window(1, 1000, DIV, 0, 0, "alt");
    run_window(0, -1, DIV, 0, 0, "minus1");
    run_window(0, 5000, DIV, 0, 1, "muted");
    run_window(0, 5000, DIV, 0, 0, "unmuted");
    for (int k = 0; k < 4; k++) begin
      run_window(2 + (k % 2), 0, DIV, int'($urandom_range(3)), int'($urandom_range(3) == 0),
                 $sformatf("rand%0d", k));
    end

    run_window(0, 777, 500, 0, 0, "partial");
    @(negedge clk_49m);
    reset = 1'b0;
    #1;
    check("midrst_out", 32'(out_sample), 0);
    check("midrst_stb", 32'(out_stb), 0);
    repeat (10) @(negedge clk_49m);
    check("midrst_out_hold", 32'(out_sample), 0);
    check("midrst_stb_hold", 32'(out_stb), 0);
    release_reset();

    run_window(0, 0, DIV, 0, 0, "step0");
    run_window(0, 8000, DIV, 0, 0, "step_a");
    run_window(0, 8000, DIV, 0, 0, "step_b");
    run_window(0, 8000, DIV, 0, 0, "step_c");
    run_window(0, 0, 8, 0, 0, "flush");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
